// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg
//   Shared definitions for the fetch front end and decode: datapath width,
//   ROM address width, the canonical NOP, base opcodes, the queue entry
//   layout and a small PC alignment helper.
package fetch_buffer_pkg;

   localparam int XLEN   = 32;
   localparam int ROM_AW = 10;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   // Major opcodes (instr[6:0]) recognised by decode.
   typedef enum logic [6:0] {
      I_IMM  = 7'b0010011,
      LOAD   = 7'b0000011,
      JAL    = 7'b1101111,
      S_TYPE = 7'b0100011,
      R_TYPE = 7'b0110011,
      B_TYPE = 7'b1100011
   } opcode_t;

   // One fetch queue slot: byte PC plus the instruction fetched from it.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Word-align a byte address (low two bits forced to zero).
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fifo2.sv
// instr_fifo2
//   Circular instruction queue with up to two pushes and two pops per cycle
//   and a single-cycle flush. Entries are {pc, instr}; program order is kept
//   by writing at tail / tail+1 and reading at head / head+1. Pointers wrap
//   modulo DEPTH, so DEPTH need not be a power of two. Storage is not reset.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   flush        : empty the queue this cycle (wins over push/pop)
//   push_n       : number of entries to enqueue (0..2)
//   push_pc1/2, push_instr1/2 : entries written at tail, tail+1
//   pop_n        : number of entries to dequeue (0..2), must not exceed count
//   count        : current occupancy
//   head_pc1/2, head_instr1/2 : entries at head, head+1 (don't-care if empty)
module instr_fifo2
   import fetch_buffer_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic [1:0]      push_n,
   input  logic [XLEN-1:0] push_pc1,
   input  logic [XLEN-1:0] push_instr1,
   input  logic [XLEN-1:0] push_pc2,
   input  logic [XLEN-1:0] push_instr2,
   input  logic [1:0]      pop_n,
   output logic [CW-1:0]   count,
   output logic [XLEN-1:0] head_pc1,
   output logic [XLEN-1:0] head_instr1,
   output logic [XLEN-1:0] head_pc2,
   output logic [XLEN-1:0] head_instr2
);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] head_nxt1;
   logic [PW-1:0] tail_nxt1;
   fetch_entry_t  rd1;
   fetch_entry_t  rd2;

   // Pointer advance by 0..2 with wrap at DEPTH (not necessarily 2^PW).
   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p,
                                              input logic [1:0]    n);
      logic [PW+1:0] s;
      s = {2'b00, p} + {{PW{1'b0}}, n};
      if (s >= (PW+2)'(DEPTH))
         s = s - (PW+2)'(DEPTH);
      return s[PW-1:0];
   endfunction

   assign head_nxt1 = ptr_add(head, 2'd1);
   assign tail_nxt1 = ptr_add(tail, 2'd1);

   // Data array: written only on accepted pushes, never cleared.
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         if (push_n != 2'd0)
            mem[tail] <= '{pc: push_pc1, instr: push_instr1};
         if (push_n == 2'd2)
            mem[tail_nxt1] <= '{pc: push_pc2, instr: push_instr2};
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         assert (int'(pop_n) <= int'(count));
         assert (int'(count) + int'(push_n) - int'(pop_n) <= DEPTH);
         head  <= ptr_add(head, pop_n);
         tail  <= ptr_add(tail, push_n);
         count <= count + CW'(push_n) - CW'(pop_n);
      end
   end

   assign rd1         = mem[head];
   assign rd2         = mem[head_nxt1];
   assign head_pc1    = rd1.pc;
   assign head_instr1 = rd1.instr;
   assign head_pc2    = rd2.pc;
   assign head_instr2 = rd2.instr;

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Instruction fetch front end. Drives a word address into a dual-issue
//   ROM (1-cycle latency, returns word and word+1), captures each response
//   into a DEPTH-entry queue and presents the two oldest entries to decode.
//   A fetch is only issued when the queue is guaranteed room for it and for
//   any response still in flight, so the queue can never overflow. A
//   redirect flushes the queue, drops any in-flight response and restarts
//   fetch at the new (word-aligned) PC.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   rom_addr           : ROM word address, pc[11:2]
//   rom_instr1/2       : ROM words at last cycle's rom_addr and rom_addr+1
//   redirect_valid/pc  : branch/jump redirect, pc[1:0] ignored
//   id_ready           : decode takes every valid output slot this cycle
//   out_valid1/2       : head / head+1 valid
//   out_instr1/2       : instructions at head / head+1
//   out_pc1/2          : their byte PCs
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [XLEN-1:0]   rom_instr1,
   input  logic [XLEN-1:0]   rom_instr2,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   input  logic              id_ready,
   output logic              out_valid1,
   output logic              out_valid2,
   output logic [XLEN-1:0]   out_instr1,
   output logic [XLEN-1:0]   out_instr2,
   output logic [XLEN-1:0]   out_pc1,
   output logic [XLEN-1:0]   out_pc2
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_req;
   logic            inflight;
   logic [CW-1:0]   count;
   logic [CW+1:0]   need;
   logic            issue;
   logic            pc_at_wrap;
   logic            req_at_wrap;
   logic [1:0]      push_n;
   logic [1:0]      pop_n;
   logic            unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign rom_addr = pc[11:2];

   // Last ROM word: its +1 partner would wrap to word 0, which belongs to
   // the next 4 KiB page, so only one instruction is taken from this fetch.
   assign pc_at_wrap  = &pc[11:2];
   assign req_at_wrap = &pc_req[11:2];

   // Space check uses occupancy before this cycle's dequeue and reserves two
   // slots for a response already on its way, so a full queue can never be
   // overrun even if decode stalls.
   assign need  = (CW+2)'(count) + (CW+2)'({inflight, 1'b0}) + (CW+2)'(2);
   assign issue = !redirect_valid && (need <= (CW+2)'(DEPTH));

   // Response capture: dropped on redirect (it belongs to the old stream).
   always_comb begin
      push_n = 2'd0;
      if (inflight && !redirect_valid)
         push_n = req_at_wrap ? 2'd1 : 2'd2;
   end

   assign out_valid1 = (count != '0);
   assign out_valid2 = (count >= CW'(2));

   // Decode takes every valid slot; a redirect flushes instead.
   always_comb begin
      pop_n = 2'd0;
      if (id_ready && !redirect_valid)
         pop_n = {1'b0, out_valid1} + {1'b0, out_valid2};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         pc_req   <= RESET_PC;
         inflight <= 1'b0;
      end else if (redirect_valid) begin
         pc       <= align_word(redirect_pc);
         inflight <= 1'b0;
      end else if (issue) begin
         pc_req   <= pc;
         pc       <= pc + (pc_at_wrap ? 32'd4 : 32'd8);
         inflight <= 1'b1;
      end else begin
         inflight <= 1'b0;
      end
   end

   instr_fifo2 #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush       (redirect_valid),
      .push_n      (push_n),
      .push_pc1    (pc_req),
      .push_instr1 (rom_instr1),
      .push_pc2    (pc_req + 32'd4),
      .push_instr2 (rom_instr2),
      .pop_n       (pop_n),
      .count       (count),
      .head_pc1    (out_pc1),
      .head_instr1 (out_instr1),
      .head_pc2    (out_pc2),
      .head_instr2 (out_instr2)
   );

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer
//   Directed scenarios followed by a random phase. A random ROM of addi-type
//   words is modelled here; a program-order scoreboard tracks the next PC
//   decode should see (reset -> RESET_PC, redirect -> aligned target,
//   otherwise +4 per consumed slot) and checks each consumed instruction
//   against the ROM word at that PC.
module tb_fetch_buffer;

   localparam int          DEPTH    = 8;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic [9:0]  rom_addr;
   logic [31:0] rom_instr1;
   logic [31:0] rom_instr2;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        out_valid1;
   logic        out_valid2;
   logic [31:0] out_instr1;
   logic [31:0] out_instr2;
   logic [31:0] out_pc1;
   logic [31:0] out_pc2;

   fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .rom_addr       (rom_addr),
      .rom_instr1     (rom_instr1),
      .rom_instr2     (rom_instr2),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .out_valid1     (out_valid1),
      .out_valid2     (out_valid2),
      .out_instr1     (out_instr1),
      .out_instr2     (out_instr2),
      .out_pc1        (out_pc1),
      .out_pc2        (out_pc2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Dual-read ROM, one cycle latency.
   logic [31:0] rom [1024];
   always @(posedge clk) begin
      rom_instr1 <= rom[rom_addr];
      rom_instr2 <= rom[rom_addr + 10'd1];
   end

   int          total = 0;
   int          bad = 0;
   int          consumed = 0;
   logic [31:0] exp_pc;
   logic        hold_pending;
   logic [31:0] hold_pc;
   logic [31:0] t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic slot(input logic v, input logic [31:0] pc, input logic [31:0] instr);
      if (v) begin
         chk("sb_pc", pc, exp_pc);
         chk("sb_instr", instr, rom[pc[11:2]]);
         exp_pc = exp_pc + 32'd4;
         consumed++;
      end
   endtask

   // Drive one cycle of inputs, score what decode takes, advance one edge.
   task automatic cyc(input logic r, input logic ready, input logic redir,
                      input logic [31:0] rpc);
      rst            = r;
      id_ready       = ready;
      redirect_valid = redir;
      redirect_pc    = rpc;
      chk("v2_without_v1", {31'b0, out_valid2 & ~out_valid1}, 32'd0);
      if (hold_pending) begin
         chk("hold_v1", {31'b0, out_valid1}, 32'd1);
         chk("hold_pc1", out_pc1, hold_pc);
      end
      if (r)
         exp_pc = RESET_PC;
      else if (redir)
         exp_pc = {rpc[31:2], 2'b00};
      else if (ready) begin
         slot(out_valid1, out_pc1, out_instr1);
         slot(out_valid2, out_pc2, out_instr2);
      end
      hold_pending = !r && !redir && !ready && out_valid1;
      hold_pc      = out_pc1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      id_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      exp_pc = RESET_PC;
      hold_pending = 1'b0;
      hold_pc = '0;
      for (int i = 0; i < 1024; i++) begin
         t = $urandom;
         rom[i] = {t[31:7], 7'b0010011};
      end

      // Reset state
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("rst_v1", {31'b0, out_valid1}, 0);
      chk("rst_v2", {31'b0, out_valid2}, 0);
      chk("rst_addr", {22'b0, rom_addr}, {22'b0, RESET_PC[11:2]});

      // Streaming: first pair two cycles after release, then a pair per cycle
      cyc(0, 1, 0, 0);
      chk("first_early_v1", {31'b0, out_valid1}, 0);
      cyc(0, 1, 0, 0);
      chk("first_v1", {31'b0, out_valid1}, 1);
      chk("first_pc1", out_pc1, 32'h0);
      chk("first_pc2", out_pc2, 32'h4);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 0, 0);
         chk("stream_v2", {31'b0, out_valid2}, 1);
         chk("stream_pc1", out_pc1, 32'(8 * (i + 1)));
      end

      // Decode stalled: queue fills to DEPTH after 4 fetches and holds
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);
      chk("stall_addr", {22'b0, rom_addr}, 32'd8);
      chk("stall_v2", {31'b0, out_valid2}, 1);
      chk("stall_pc1", out_pc1, 32'h0);
      chk("stall_pc2", out_pc2, 32'h4);
      for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0);

      // Redirect with a response in flight
      cyc(0, 1, 1, 32'h0000_0106);
      chk("redir_v1_a", {31'b0, out_valid1}, 0);
      cyc(0, 1, 0, 0);
      chk("redir_v1_b", {31'b0, out_valid1}, 0);
      cyc(0, 1, 0, 0);
      chk("redir_v1_c", {31'b0, out_valid1}, 1);
      chk("redir_pc1", out_pc1, 32'h104);
      chk("redir_pc2", out_pc2, 32'h108);

      // Last ROM word: single push, then continue at 0x1000 from word 0
      cyc(0, 1, 1, 32'h0000_0FFC);
      chk("wrap_addr_a", {22'b0, rom_addr}, 32'h3FF);
      cyc(0, 1, 0, 0);
      chk("wrap_addr_b", {22'b0, rom_addr}, 32'h0);
      cyc(0, 1, 0, 0);
      chk("wrap_v1", {31'b0, out_valid1}, 1);
      chk("wrap_v2", {31'b0, out_valid2}, 0);
      chk("wrap_pc1", out_pc1, 32'hFFC);
      cyc(0, 1, 0, 0);
      chk("wrap_pair_v2", {31'b0, out_valid2}, 1);
      chk("wrap_pair_pc1", out_pc1, 32'h1000);
      chk("wrap_pair_pc2", out_pc2, 32'h1004);

      // Fill to 7 entries (1 + 2 + 2 + 2), then redirect while decode ready
      cyc(0, 0, 1, 32'h0000_0FFC);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
      chk("fill7_addr", {22'b0, rom_addr}, 32'd6);
      chk("fill7_pc1", out_pc1, 32'hFFC);
      cyc(0, 1, 1, 32'h0000_0200);
      chk("flush_v1", {31'b0, out_valid1}, 0);
      chk("flush_v2", {31'b0, out_valid2}, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk("flush_next_pc1", out_pc1, 32'h200);

      // Reset mid-burst
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
      chk("midrst_v1", {31'b0, out_valid1}, 0);
      chk("midrst_addr", {22'b0, rom_addr}, {22'b0, RESET_PC[11:2]});
      cyc(0, 1, 0, 0);
      chk("midrst_v1_b", {31'b0, out_valid1}, 0);
      cyc(0, 1, 0, 0);
      chk("midrst_pc1", out_pc1, RESET_PC);

      // Random traffic
      consumed = 0;
      for (int i = 0; i < 3000; i++) begin
         logic r, rdy, rd;
         r   = ($urandom_range(0, 299) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         rd  = ($urandom_range(0, 29) == 0);
         cyc(r, rdy, rd, $urandom);
      end
      chk("progress", {31'b0, consumed > 1000}, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 8: queue capacity in instruction entries; even, at least 4.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1: synchronous reset, active-high.
REQ-005 Port rom_addr, output, 10: word address to the dual-issue ROM, equal to pc[11:2].
REQ-006 Port rom_instr1, input, 32: ROM word at the address presented last cycle.
REQ-007 Port rom_instr2, input, 32: ROM word at that address plus 1.
REQ-008 Port redirect_valid, input, 1: branch/JAL redirect request.
REQ-009 Port redirect_pc, input, 32: new fetch PC; bits [1:0] are ignored and treated as 0.
REQ-010 Port id_ready, input, 1: decode consumes every valid output slot this cycle.
REQ-011 Ports out_valid1/out_valid2, output, 1 each: head and head+1 entries are valid.
REQ-012 Ports out_instr1/out_instr2, output, 32 each: instructions at the head and head+1.
REQ-013 Ports out_pc1/out_pc2, output, 32 each: byte PCs of those instructions.

Function
REQ-014 ROM read latency is exactly 1 cycle; the block presents rom_addr continuously and tracks requests with a 1-bit inflight flag.
REQ-015 Issue condition: issue a fetch in a cycle iff !redirect_valid and count + 2*inflight + 2 <= DEPTH, using count before this cycle's dequeue.
REQ-016 On issue, inflight is set next cycle and pc advances by 8; otherwise pc holds and inflight clears.
REQ-017 In the cycle after an issue, capture the response: push {pc_req, rom_instr1} then {pc_req+4, rom_instr2}; pc_req is the registered PC of the request.
REQ-018 Wrap boundary: when pc_req[11:2]==1023, push only rom_instr1, and the issuing cycle advances pc by 4 instead of 8.
REQ-019 Output slots: out_valid1 = count>=1 and out_valid2 = count>=2; out_valid2 is never 1 while out_valid1 is 0.
REQ-020 Dequeue: when id_ready=1, remove out_valid1+out_valid2 entries (0, 1 or 2); when id_ready=0, outputs are stable.
REQ-021 Enqueue and dequeue in the same cycle are both applied: count_next = count + pushed - popped.
REQ-022 Overflow never occurs; the issue condition guarantees it, and an assertion checks it.
REQ-023 Redirect has priority over all other activity. In the redirect cycle:
- the queue is flushed (count=0 next cycle);
- a response arriving that cycle is discarded;
- inflight is cleared;
- pc = {redirect_pc[31:2],2'b00} next cycle;
- no fetch is issued.
REQ-024 Entries remain in program order; the head pointer and tail pointer each wrap modulo DEPTH.
REQ-025 Output data of invalid slots is don't-care and must not be relied upon.

Reset
REQ-026 While rst=1 at posedge:
- pc=RESET_PC, so rom_addr=RESET_PC[11:2];
- count, head and tail = 0;
- inflight=0;
- out_valid1 = out_valid2 = 0.
REQ-027 Reset asserted mid-operation discards queue contents and any inflight response; the first issue occurs in the first cycle after rst deasserts.
REQ-028 Queue data storage is not reset.

Structure
REQ-029 A shared package holds:
- XLEN=32;
- ROM_AW=10;
- NOP=32'h0000_0013;
- the opcode constants (I_IMM, LOAD, JAL, S_TYPE, R_TYPE, B_TYPE), shared with decode.
REQ-030 Storage is one sub-module, instr_fifo2: a circular buffer with dual push, dual pop and flush, DEPTH entries of {pc, instr}. fetch_buffer holds the PC, inflight tracking and the issue/redirect logic.

Verification
REQ-031 Reset then id_ready=1 continuously, ROM preloaded with addi words:
- first valid outputs appear 2 cycles after reset release, with out_pc1=0, out_pc2=4;
- pairs follow each cycle at PCs 8/12, 16/20, and so on.
REQ-032 id_ready=0 with DEPTH=8: fetches stop after count reaches 8 (4 issues); outputs hold PC 0/4 unchanged; no entry is lost or duplicated when id_ready returns to 1.
REQ-033 Redirect to 32'h0000_0106 while a response is inflight: the next valid pair is PC 0x104/0x108; no instruction from the old stream appears after the redirect cycle.
REQ-034 Redirect to 0xFFC (word 1023): one entry is pushed, PC 0xFFC; the next pair is PC 0x1000/0x1004, with rom_addr wrapping to 0.
REQ-035 Fill the queue to 7 entries; a redirect and id_ready=1 in the same cycle leave the queue empty; rst=1 mid-burst leaves out_valid1=0 next cycle and restarts from RESET_PC.
REQ-036 A scoreboard checks the random-ROM program order: the out_pc sequence is contiguous except at redirects, and each instruction equals the ROM word at pc>>2.
